// File: rtl/vram_port_arbiter_if.sv
// Signal bundle between the video-memory port arbiter, the host write path,
// the renderer read path and the memory macro.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              host_wr_valid;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  host_wr_valid, host_wr_addr, host_wr_data, rd_req, rd_addr, mem_rdata,
        output host_wr_ready, rd_gnt, rd_valid, rd_data, mem_addr, mem_wdata, mem_we,
               fifo_count
    );

    modport master (
        output host_wr_valid, host_wr_addr, host_wr_data, rd_req, rd_addr, mem_rdata,
        input  host_wr_ready, rd_gnt, rd_valid, rd_data, mem_addr, mem_wdata, mem_we,
               fifo_count
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port video memory arbiter: renderer reads win, host writes are queued
// and drained on free cycles, with a bounded-starvation forced write.
module vram_port_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    vram_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(MAX_STALL + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ST_W-1:0]   stall;
    logic              rd_vld_p1;

    logic full, nonempty, force_wr, rd_gnt, wr_gnt, push;

    function automatic logic [ST_W-1:0] sat_inc(input logic [ST_W-1:0] v);
        return (v == ST_W'(MAX_STALL)) ? v : v + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign nonempty = (count != '0);
    assign force_wr = nonempty && (stall == ST_W'(MAX_STALL));
    assign rd_gnt   = bus.rd_req && !force_wr;
    assign wr_gnt   = nonempty && !rd_gnt;
    // Ready is held low throughout reset so nothing is accepted into a FIFO being cleared.
    assign bus.host_wr_ready = reset_n && !full;
    assign push              = bus.host_wr_valid && bus.host_wr_ready;

    assign bus.rd_gnt     = rd_gnt;
    assign bus.fifo_count = count;
    assign bus.rd_valid   = rd_vld_p1;
    assign bus.rd_data    = rd_vld_p1 ? bus.mem_rdata : '0;

    always_comb begin
        bus.mem_addr  = bus.rd_addr;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (!rd_gnt && wr_gnt) begin
            bus.mem_addr  = addr_q[rd_ptr];
            bus.mem_wdata = data_q[rd_ptr];
            bus.mem_we    = 1'b1;
        end
    end

    // p0 -> p1: FIFO storage (data only, never reset)
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.host_wr_addr;
            data_q[wr_ptr] <= bus.host_wr_data;
        end
    end

    // p0 -> p1: FIFO pointers, stall counter and read-return valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stall     <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr_gnt)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, wr_gnt})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!nonempty || wr_gnt)
                stall <= '0;
            else if (rd_gnt)
                stall <= sat_inc(stall);
            rd_vld_p1 <= rd_gnt;
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised and directed bench for vram_port_arbiter against a queue-based
// reference model of the arbitration rules and a synchronous-read memory model.
module tb_vram_port_arbiter;
    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 4;
    localparam int MAX_STALL = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    vram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    function automatic logic [31:0] init_word(input logic [10:0] a);
        if (a == 11'h040)
            return 32'h00AB_CDEF;
        return {21'h0, a} ^ 32'h5A5A_0000;
    endfunction

    // Memory macro model: one port, read data one cycle after the address.
    logic [31:0] mem [0:2047];
    bit          written [0:2047];
    logic [31:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        rdata_q <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
    end
    assign bus.mem_rdata = rdata_q;

    // Reference model state
    typedef struct packed {
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t         q[$];
    logic [31:0] ref_mem [int];
    int          stall = 0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] ref_rd(input logic [10:0] a);
        if (ref_mem.exists(int'(a)))
            return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        stall    = 0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic step(input logic v, input logic [10:0] wa, input logic [31:0] wd,
                        input logic rq, input logic [10:0] ra);
        bit          ne, frc, rg, wg, rdy;
        logic [10:0] ea;
        logic [31:0] rv;
        bus.host_wr_valid = v;
        bus.host_wr_addr  = wa;
        bus.host_wr_data  = wd;
        bus.rd_req        = rq;
        bus.rd_addr       = ra;
        @(negedge clk);
        ne  = (q.size() > 0);
        frc = ne && (stall == MAX_STALL);
        rg  = rq && !frc;
        wg  = ne && !rg;
        rdy = (q.size() < DEPTH);
        ea  = wg ? q[0].a : ra;
        chk("rd_gnt", 64'(bus.rd_gnt), 64'(rg));
        chk("mem_we", 64'(bus.mem_we), 64'(wg));
        chk("mem_addr", 64'(bus.mem_addr), 64'(ea));
        if (wg)
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(q[0].d));
        chk("host_wr_ready", 64'(bus.host_wr_ready), 64'(rdy));
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("rd_valid", 64'(bus.rd_valid), 64'(m_rvalid));
        chk("rd_data", 64'(bus.rd_data), 64'(m_rdata));
        @(posedge clk);
        rv = ref_rd(ra);
        if (wg) begin
            ref_mem[int'(q[0].a)] = q[0].d;
            void'(q.pop_front());
        end
        if (v && rdy)
            q.push_back(wr_t'({wa, wd}));
        if (!ne || wg)
            stall = 0;
        else if (rg && stall < MAX_STALL)
            stall++;
        m_rvalid = rg;
        m_rdata  = rg ? rv : 32'h0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 11'h0, 32'h0, 1'b0, 11'h0);
    endtask

    initial begin
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = 11'h7FF;
        bus.host_wr_data  = 32'hFFFF_FFFF;
        bus.rd_req        = 1'b0;
        bus.rd_addr       = 11'h0;
        reset_n           = 1'b0;

        // Reset held three cycles with a pending host write
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 64'(bus.host_wr_ready), 64'(0));
            chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
            chk("rst_count", 64'(bus.fifo_count), 64'(0));
            chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
            @(posedge clk);
        end
        #1;
        reset_n = 1'b1;
        bus.host_wr_valid = 1'b0;
        model_clear();
        #1;
        chk("ready_after_rst", 64'(bus.host_wr_ready), 64'(1));

        // Single write, no reads
        step(1'b1, 11'h012, 32'hDEAD_BEEF, 1'b0, 11'h0);
        idle(2);

        // Five back-to-back writes against continuous reads, then forced writes
        for (int i = 0; i < 5; i++)
            step(1'b1, 11'(11'h100 + i), 32'hA000_0000 + i, 1'b1, 11'h200);
        repeat (40) step(1'b0, 11'h0, 32'h0, 1'b1, 11'h200);
        idle(6);

        // Half-full FIFO with simultaneous push and pop
        step(1'b1, 11'h300, 32'h1111_1111, 1'b1, 11'h201);
        step(1'b1, 11'h301, 32'h2222_2222, 1'b1, 11'h201);
        step(1'b1, 11'h302, 32'h3333_3333, 1'b0, 11'h0);
        step(1'b1, 11'h303, 32'h4444_4444, 1'b0, 11'h0);
        idle(6);

        // Read latency on a preloaded word with the FIFO empty
        step(1'b0, 11'h0, 32'h0, 1'b1, 11'h040);
        idle(1);
        // Read-back of an earlier drained write
        step(1'b0, 11'h0, 32'h0, 1'b1, 11'h012);
        idle(1);

        // Reset pulse mid-drain with three queued entries
        for (int i = 0; i < 3; i++)
            step(1'b1, 11'(11'h400 + i), 32'hB000_0000 + i, 1'b1, 11'h202);
        bus.rd_req        = 1'b0;
        bus.host_wr_valid = 1'b0;
        reset_n           = 1'b0;
        #1;
        chk("midrst_count", 64'(bus.fifo_count), 64'(0));
        chk("midrst_rd_valid", 64'(bus.rd_valid), 64'(0));
        model_clear();
        @(negedge clk);
        chk("midrst_mem_we", 64'(bus.mem_we), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 3) != 0, 11'($urandom_range(0, 2047)), $urandom,
                 ($urandom % 4) != 0, 11'($urandom_range(0, 2047)));
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port, synchronous-read video memory (tile buffer, tile/sprite graphics, palette or OAM instance) between host bus writes and renderer reads.
- Host writes arrive from the address decoder's per-memory write strobe, address and data outputs. They are queued in a small FIFO and drained on cycles the renderer leaves free.
- Renderer reads have priority, subject to a bounded-starvation rule so queued host writes always complete.

Parameters:
ADDR_W, 11, memory word-address width
DATA_W, 32, memory data width
DEPTH, 4, host write FIFO entries; power of 2, >= 2
MAX_STALL, 15, max consecutive renderer grants while the FIFO is non-empty before one write is forced

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
host_wr_valid  in  1  host write request (decoder rw strobe)
host_wr_addr  in  ADDR_W  host write address
host_wr_data  in  DATA_W  host write data
host_wr_ready  out  1  FIFO can accept a write this cycle
rd_req  in  1  renderer read request
rd_addr  in  ADDR_W  renderer read address
rd_gnt  out  1  renderer read issued to memory this cycle
rd_valid  out  1  rd_data holds data for the read granted last cycle
rd_data  out  DATA_W  read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data; 1-cycle latency after address
fifo_count  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (reset_n low, async):
  - FIFO empty, fifo_count=0, stall counter=0, rd_valid=0.
  - host_wr_ready=0 while reset_n is low; 1 from the first cycle after release.
- FIFO:
  - host_wr_ready = !full (combinational). A push occurs when host_wr_valid && host_wr_ready.
  - When full, no push is accepted, even if a pop happens the same cycle.
  - Pointers wrap modulo DEPTH. fifo_count updates at the clock edge: +1 on push, -1 on pop, unchanged on both or neither.
  - A write pushed into an empty FIFO can reach memory no earlier than the next cycle. The FIFO has no bypass.
- Arbitration (combinational each cycle; stall counter registered):
  - force_wr = fifo non-empty && stall == MAX_STALL.
  - rd_gnt = rd_req && !force_wr.
  - wr_gnt = fifo non-empty && !rd_gnt. A pop occurs on wr_gnt.
  - If rd_gnt: mem_addr = rd_addr, mem_we = 0.
  - Else if wr_gnt: mem_addr = FIFO head address, mem_wdata = FIFO head data, mem_we = 1.
  - Otherwise: mem_we = 0, mem_addr = rd_addr, mem_wdata = 0.
- Stall counter:
  - Cleared on wr_gnt or when the FIFO is empty.
  - Incremented on rd_gnt while the FIFO is non-empty.
  - Saturates at MAX_STALL.
- Read return:
  - rd_valid is the registered value of rd_gnt.
  - rd_data = mem_rdata when rd_valid, else 0.
  - Read latency is exactly 1 cycle from grant.
  - When rd_req is high but rd_gnt is low, the renderer holds rd_addr and retries the next cycle.
- Ordering and hazards:
  - Host writes reach memory strictly in push order.
  - A renderer read of an address with a queued write returns the old value. There is no forwarding; software writes during blanking.
- Host writes are never dropped. Backpressure is only via host_wr_ready.
- A reset asserted mid-operation discards queued writes and any in-flight rd_valid.

Test Plan:
- Reset then idle: reset_n low 3 cycles with host_wr_valid=1 -> host_wr_ready=0, mem_we=0, fifo_count=0. After release, ready=1.
- Single write, no reads: push addr 0x012, data 0xDEADBEEF -> fifo_count=1 next cycle; that cycle mem_we=1 with the same addr/data; then fifo_count=0.
- Back-to-back 5 writes with DEPTH=4 and rd_req held 1: 4 accepted, ready=0 on the 5th. After MAX_STALL=15 consecutive rd_gnt cycles, one cycle has rd_gnt=0 and mem_we=1 writing the first pushed entry; the stall counter clears.
- Simultaneous push and pop on a half-full FIFO (count=2, rd_req=0): fifo_count stays 2; memory writes appear in push order.
- Read latency: rd_req=1, rd_addr=0x040, FIFO empty, memory preloaded with 0x00ABCDEF -> rd_gnt=1 the same cycle; next cycle rd_valid=1, rd_data=0x00ABCDEF.
- Reset mid-drain: FIFO holding 3 entries, reset_n pulsed low for 1 cycle -> fifo_count=0 immediately. No further mem_we occurs until new writes are pushed.
